// File: rtl/pipe_stage_reg_if.sv
// Handshake, flush/redirect and status bundle for one pipeline stage register.
// The stage itself uses the slave modport; the producer/consumer side uses master.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic [ADDR_W-1:0] flush_addr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_data, flush, flush_addr, out_ready,
        input  in_ready, out_valid, out_data, redirect_valid, redirect_addr,
               occupancy, stall_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, flush_addr, out_ready,
        output in_ready, out_valid, out_data, redirect_valid, redirect_addr,
               occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with flush/redirect and a
// saturating back-pressure counter. in_ready depends only on registered state.
module pipe_stage_reg #(
    parameter int                DATA_W = 96,
    parameter int                ADDR_W = 32,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
    parameter int                CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipe_stage_reg_if.slave       bus
);
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [1:0]        r_occupancy;
    logic              r_redirect_valid;
    logic [ADDR_W-1:0] r_redirect_addr;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_valid_nx;
    logic [DATA_W-1:0] w_main_data_nx;
    logic              w_skid_valid_nx;
    logic [DATA_W-1:0] w_skid_data_nx;

    assign w_in_ready = !r_skid_valid && !reset;
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_main_valid && bus.out_ready;

    // Next-state selection for the main/skid entries; flush overrides everything.
    always_comb begin
        w_main_valid_nx = r_main_valid;
        w_main_data_nx  = r_main_data;
        w_skid_valid_nx = r_skid_valid;
        w_skid_data_nx  = r_skid_data;
        if (bus.flush) begin
            w_main_valid_nx = 1'b0;
            w_main_data_nx  = BUBBLE;
            w_skid_valid_nx = 1'b0;
            w_skid_data_nx  = BUBBLE;
        end else if (!r_main_valid) begin
            if (w_in_fire) begin
                w_main_valid_nx = 1'b1;
                w_main_data_nx  = bus.in_data;
            end else begin
                w_main_valid_nx = 1'b0;
            end
        end else if (w_out_fire) begin
            if (r_skid_valid) begin
                // skid is older than any new input, so it drains first
                w_main_data_nx  = r_skid_data;
                w_skid_valid_nx = 1'b0;
                w_skid_data_nx  = BUBBLE;
            end else if (w_in_fire) begin
                w_main_data_nx  = bus.in_data;
            end else begin
                w_main_valid_nx = 1'b0;
                w_main_data_nx  = BUBBLE;
            end
        end else if (w_in_fire) begin
            w_skid_valid_nx = 1'b1;
            w_skid_data_nx  = bus.in_data;
        end else begin
            w_skid_valid_nx = r_skid_valid;
        end
    end

    // Entry storage, occupancy and redirect registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_valid     <= 1'b0;
            r_main_data      <= BUBBLE;
            r_skid_valid     <= 1'b0;
            r_skid_data      <= BUBBLE;
            r_occupancy      <= 2'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_addr  <= {ADDR_W{1'b0}};
        end else begin
            r_main_valid     <= w_main_valid_nx;
            r_main_data      <= w_main_data_nx;
            r_skid_valid     <= w_skid_valid_nx;
            r_skid_data      <= w_skid_data_nx;
            r_occupancy      <= {1'b0, w_main_valid_nx} + {1'b0, w_skid_valid_nx};
            r_redirect_valid <= bus.flush;
            if (bus.flush) begin
                r_redirect_addr <= bus.flush_addr;
            end else begin
                r_redirect_addr <= r_redirect_addr;
            end
        end
    end

    // Saturating back-pressure counter; only reset clears it, flush does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (r_main_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_main_valid;
    assign bus.out_data       = r_main_data;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_addr  = r_redirect_addr;
    assign bus.occupancy      = r_occupancy;
    assign bus.stall_cnt      = r_stall_cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, back-pressure, flush/redirect,
// stall-counter saturation and asynchronous reset with a full stage.
module tb_pipe_stage_reg;
    localparam int           DW  = 96;
    localparam int           AW  = 32;
    localparam int           CW  = 2;
    localparam logic [DW-1:0] BUB = 96'h0000_0000_0000_0000_DEAD_BEEF;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    pipe_stage_reg_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    pipe_stage_reg #(.DATA_W(DW), .ADDR_W(AW), .BUBBLE(BUB), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic [DW-1:0] od,
                             input logic ir, input logic [1:0] occ);
        chk({tag, ".out_valid"}, 128'(bus.out_valid), 128'(ov));
        chk({tag, ".out_data"},  128'(bus.out_data),  128'(od));
        chk({tag, ".in_ready"},  128'(bus.in_ready),  128'(ir));
        chk({tag, ".occ"},       128'(bus.occupancy), 128'(occ));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.flush      = 1'b0;
        bus.flush_addr = '0;
        bus.out_ready  = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk_state("rst", 1'b0, BUB, 1'b0, 2'd0);
        chk("rst.stall", 128'(bus.stall_cnt), 128'(0));
        chk("rst.rv", 128'(bus.redirect_valid), 128'(0));
        chk("rst.ra", 128'(bus.redirect_addr), 128'(0));
        tick();
        reset = 1'b0;
        #1;
        chk("post_rst.in_ready", 128'(bus.in_ready), 128'(1));

        // streaming
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = DW'(i);
            tick();
            chk_state($sformatf("stream%0d", i), 1'b1, DW'(i), 1'b1, 2'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk_state("stream_drain", 1'b0, BUB, 1'b1, 2'd0);
        chk("stream.stall", 128'(bus.stall_cnt), 128'(0));

        // back-pressure
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(32'hA);
        tick();
        chk_state("bp_a", 1'b1, DW'(32'hA), 1'b1, 2'd1);
        bus.in_data = DW'(32'hB);
        tick();
        chk_state("bp_ab", 1'b1, DW'(32'hA), 1'b0, 2'd2);
        chk("bp.stall", 128'(bus.stall_cnt), 128'(1));
        bus.in_data   = DW'(32'hC);
        tick();
        chk_state("bp_hold", 1'b1, DW'(32'hA), 1'b0, 2'd2);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk_state("bp_b", 1'b1, DW'(32'hB), 1'b1, 2'd1);
        tick();
        chk_state("bp_empty", 1'b0, BUB, 1'b1, 2'd0);

        // flush while full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(32'h11);
        tick();
        bus.in_data   = DW'(32'h22);
        tick();
        chk("fl.pre_occ", 128'(bus.occupancy), 128'(2));
        bus.in_data    = DW'(32'h33);
        bus.flush      = 1'b1;
        bus.flush_addr = 32'h0000_0040;
        tick();
        chk_state("fl", 1'b0, BUB, 1'b1, 2'd0);
        chk("fl.rv", 128'(bus.redirect_valid), 128'(1));
        chk("fl.ra", 128'(bus.redirect_addr), 128'(32'h40));
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("fl.rv_end", 128'(bus.redirect_valid), 128'(0));
        chk("fl.ra_hold", 128'(bus.redirect_addr), 128'(32'h40));
        chk("fl.no_deliver", 128'(bus.out_valid), 128'(0));

        // back-to-back flush
        bus.flush      = 1'b1;
        bus.flush_addr = 32'h0000_0080;
        tick();
        chk("fl2.rv", 128'(bus.redirect_valid), 128'(1));
        chk("fl2.ra", 128'(bus.redirect_addr), 128'(32'h80));
        bus.flush_addr = 32'h0000_00C0;
        tick();
        chk("fl3.rv", 128'(bus.redirect_valid), 128'(1));
        chk("fl3.ra", 128'(bus.redirect_addr), 128'(32'hC0));
        bus.flush = 1'b0;
        tick();
        chk("fl4.rv", 128'(bus.redirect_valid), 128'(0));
        chk("fl4.ra", 128'(bus.redirect_addr), 128'(32'hC0));

        // async reset with a full stage
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = DW'(32'h44);
        tick();
        bus.in_data   = DW'(32'h55);
        tick();
        chk("ar.pre_occ", 128'(bus.occupancy), 128'(2));
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_state("ar", 1'b0, BUB, 1'b0, 2'd0);
        chk("ar.stall", 128'(bus.stall_cnt), 128'(0));
        chk("ar.ra", 128'(bus.redirect_addr), 128'(0));
        chk("ar.rv", 128'(bus.redirect_valid), 128'(0));
        tick();
        reset = 1'b0;
        #1;
        chk_state("ar_post", 1'b0, BUB, 1'b1, 2'd0);
        tick();
        chk("ar_post2.out_valid", 128'(bus.out_valid), 128'(0));

        // stall counter saturation (CNT_W=2)
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(32'h5);
        tick();
        bus.in_valid = 1'b0;
        chk("st0", 128'(bus.stall_cnt), 128'(0));
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("st%0d", i), 128'(bus.stall_cnt), 128'((i > 3) ? 3 : i));
        end
        bus.flush      = 1'b1;
        bus.flush_addr = 32'h0000_0100;
        tick();
        bus.flush = 1'b0;
        chk("st_flush", 128'(bus.stall_cnt), 128'(3));
        chk("st_flush.ov", 128'(bus.out_valid), 128'(0));
        tick();
        chk("st_after", 128'(bus.stall_cnt), 128'(3));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DATA_W, 96, width of the stage payload (for example instruction, pc_current and pc_next).
- ADDR_W, 32, width of the redirect (branch) address.
- BUBBLE, {DATA_W{1'b0}}, payload value driven when no entry is valid.
- CNT_W, 16, width of the stall counter.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, input, 1, the single clock; all state updates on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, upstream payload valid.
- in_ready, output, 1, stage can accept a payload.
- in_data, input, DATA_W, upstream payload.
- flush, input, 1, kill all in-flight entries and request a redirect.
- flush_addr, input, ADDR_W, redirect target sampled with flush.
- out_valid, output, 1, downstream payload valid.
- out_ready, input, 1, downstream accepts the payload.
- out_data, output, DATA_W, downstream payload.
- redirect_valid, output, 1, one-cycle redirect pulse.
- redirect_addr, output, ADDR_W, redirect target.
- occupancy, output, 2, number of valid entries (0 to 2).
- stall_cnt, output, CNT_W, saturating count of back-pressured cycles.

Function
REQ-003 Storage SHALL be two entries, main (drives out_data/out_valid) and skid, each a payload plus valid flag, with delivery strictly in FIFO order.
REQ-004 in_ready SHALL equal !skid_valid && !reset, decoded from registered state only, with no combinational path from out_ready.
REQ-005 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-006 With main empty, an input transfer SHALL load main, and out_valid SHALL be 1 on the next cycle (1-cycle latency).
REQ-007 With main valid and an output transfer, any input transfer SHALL reload main in the same edge (full throughput, no bubble); with no input, main SHALL be cleared.
REQ-008 With main valid, no output transfer and an input transfer, the payload SHALL be written to skid and in_ready SHALL deassert on the next cycle.
REQ-009 With skid valid and an output transfer, skid SHALL move into main and skid SHALL clear, so in_ready reasserts on the next cycle.
REQ-010 When an entry is not valid, its payload register SHALL hold BUBBLE, so out_data equals BUBBLE whenever out_valid is 0.
REQ-011 flush SHALL take priority over all other events: both valid flags clear, both payloads become BUBBLE, and any input or output transfer in that cycle SHALL be discarded (the input counts as accepted and dropped).
REQ-012 The cycle after flush is sampled, redirect_valid SHALL be 1 for exactly one cycle with redirect_addr equal to the sampled flush_addr; redirect_addr SHALL hold its value until the next flush.
REQ-013 flush asserted on consecutive cycles SHALL produce redirect_valid on each following cycle, each carrying that cycle's flush_addr.
REQ-014 occupancy SHALL equal main_valid + skid_valid as registered.
REQ-015 stall_cnt SHALL increment on each cycle with out_valid && !out_ready, SHALL saturate at 2^CNT_W-1, SHALL be unaffected by flush, and SHALL be cleared only by reset.

Reset
REQ-016 While reset is high, the block SHALL asynchronously force: out_valid=0, skid/main valid=0, payloads=BUBBLE, in_ready=0, redirect_valid=0, redirect_addr=0, occupancy=0, stall_cnt=0.
REQ-017 After reset deasserts, in_ready SHALL be 1 in the first cycle, and a reset asserted mid-transfer SHALL discard all entries with no partial output.

Verification
REQ-018 The bench SHALL cover at least the following directed scenarios:
- Streaming: in_valid=1 and out_ready=1 continuously with payloads 1,2,3,4 -> out_data 1,2,3,4 on consecutive cycles starting 1 cycle after the first, with occupancy held at 1.
- Back-pressure: out_ready=0 while A,B are offered -> A in main, B in skid, in_ready=0, occupancy=2; then out_ready=1 -> A then B delivered, in_ready=1 one cycle after A leaves.
- Flush while full (occupancy=2) with flush_addr=0x00000040 and in_valid=1 -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, redirect_valid=1 and redirect_addr=0x40 for exactly one cycle; the offered input is never delivered.
- Stall counter with CNT_W=2: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt sequence 1,2,3,3,3; a flush does not clear it.
- Asynchronous reset asserted between clock edges with occupancy=2 -> all outputs reach their REQ-016 values before the next edge; first post-reset cycle has in_ready=1 and out_valid=0.
